// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing recovery on the pclk domain.
// Registers hs/vs/rgb once and recovers hcount/vcount/de aligned with a
// two-cycle delayed rgb. It also measures line length and lines per frame,
// tracks timing lock, and counts lock losses.
// Optional feature: define VGA_SYNC_DECODER_CHECKSUM_EN to build the per-frame
// rotate-xor checksum of active pixels. Without it, frame_sum is constant 0.
module vga_sync_decoder #(
  parameter int unsigned H_START  = 280,
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 768,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [11:0] rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        de,
  output logic [11:0] rgb_out,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_sum,
  output logic        frame_done
);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} lock_state_e;

  localparam logic [10:0] CntMax = 11'h7ff;
  localparam logic [31:0] HBeg   = 32'(H_START);
  localparam logic [31:0] HEnd   = 32'(H_START + H_ACTIVE);
  localparam logic [31:0] VBeg   = 32'(V_START);
  localparam logic [31:0] VEnd   = 32'(V_START + V_ACTIVE);

  // Input stage: syncs are held as "active" flags so polarity is resolved once
  logic        hs_act_q, vs_act_q;
  logic        hs_prev_q, vs_prev_q;
  logic [11:0] rgb_q;

  // Register the pins, plus one extra tap of the sync flags for edge detection
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hs_act_q  <= 1'b0;
      vs_act_q  <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      hs_act_q  <= (hs == HS_POL);
      vs_act_q  <= (vs == VS_POL);
      hs_prev_q <= hs_act_q;
      vs_prev_q <= vs_act_q;
      rgb_q     <= rgb;
    end
  end

  logic hs_edge, vs_edge, frame_start;

  // Counter and measurement state
  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        vpend_q, vpend_d;
  logic        de_q, de_d;
  logic [11:0] rgb_out_q;
  logic [10:0] line_len_q, line_len_d;
  logic [10:0] frame_lines_q, frame_lines_d;
  logic        frame_done_q;
  logic [10:0] line_meas, lines_meas;

  assign hs_edge     = hs_act_q & ~hs_prev_q;
  assign vs_edge     = vs_act_q & ~vs_prev_q;
  // A pending vs (or one arriving with this hs) makes the hs edge a frame start
  assign frame_start = hs_edge & (vpend_q | vs_edge);
  // Wraps to 0 if the count was saturated; a stuck line has no meaningful length
  assign line_meas   = hcount_q + 11'd1;
  assign lines_meas  = vcount_q + 11'd1;

  // Next-state for the recovered counts, frame-start pending flag and measurements
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    vpend_d       = vpend_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;

    if (hs_edge) begin
      hcount_d   = 11'd0;
      line_len_d = line_meas;
    end else if (hcount_q != CntMax) begin
      hcount_d = hcount_q + 11'd1;
    end

    if (frame_start) begin
      vcount_d      = 11'd0;
      vpend_d       = 1'b0;
      frame_lines_d = lines_meas;
    end else begin
      if (hs_edge && (vcount_q != CntMax)) begin
        vcount_d = vcount_q + 11'd1;
      end
      if (vs_edge) begin
        vpend_d = 1'b1;
      end
    end
  end

  // Active window decode on the next counts so de lines up with hcount_out
  always_comb begin
    de_d = ({21'd0, hcount_d} >= HBeg) && ({21'd0, hcount_d} < HEnd) &&
           ({21'd0, vcount_d} >= VBeg) && ({21'd0, vcount_d} < VEnd);
  end

  // Counter, measurement and aligned-pixel registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      vpend_q       <= 1'b0;
      de_q          <= 1'b0;
      rgb_out_q     <= 12'h000;
      line_len_q    <= 11'd0;
      frame_lines_q <= 11'd0;
      frame_done_q  <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vpend_q       <= vpend_d;
      de_q          <= de_d;
      rgb_out_q     <= rgb_q;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_done_q  <= frame_start;
    end
  end

  // Lock tracking
  lock_state_e state_q, state_d;
  logic [10:0] ref_line_q, ref_line_d;
  logic [10:0] ref_lines_q, ref_lines_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        lock_lost;

  // Lock FSM next-state: reference capture, confirmation and loss detection
  always_comb begin
    state_d     = state_q;
    ref_line_d  = ref_line_q;
    ref_lines_d = ref_lines_q;
    lock_lost   = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (frame_start) begin
          ref_line_d  = line_meas;
          ref_lines_d = lines_meas;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (frame_start) begin
          if ((line_meas == ref_line_q) && (lines_meas == ref_lines_q)) begin
            state_d = StLocked;
          end else begin
            ref_line_d  = line_meas;
            ref_lines_d = lines_meas;
          end
        end
      end
      StLocked: begin
        // Every line is policed once locked, frame height only at frame start
        if ((hs_edge && (line_meas != ref_line_q)) ||
            (frame_start && (lines_meas != ref_lines_q))) begin
          lock_lost = 1'b1;
          state_d   = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase

    err_d     = lock_lost;
    err_cnt_d = err_cnt_q;
    if (lock_lost && (err_cnt_q != 8'hff)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Lock FSM state and error bookkeeping registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= StSearch;
      ref_line_q  <= 11'd0;
      ref_lines_q <= 11'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      ref_line_q  <= ref_line_d;
      ref_lines_q <= ref_lines_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] frame_sum_q, frame_sum_d;

  // Rotate-xor accumulate active pixels; hand off and clear at frame start
  always_comb begin
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    if (frame_start) begin
      frame_sum_d = acc_q;
      acc_d       = 16'h0000;
    end else if (de_d) begin
      acc_d = {acc_q[14:0], acc_q[15]} ^ {4'b0000, rgb_q};
    end
  end

  // Checksum registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      acc_q       <= 16'h0000;
      frame_sum_q <= 16'h0000;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'h0000;
`endif

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign de          = de_q;
  assign rgb_out     = rgb_out_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = (state_q == StLocked);
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized pixel-stream bench for vga_sync_decoder with
// a sample-by-sample behavioural reference model and directed scenario checks.
module tb_vga_sync_decoder;

  // Reduced geometry keeps whole frames short
  localparam int H_ST  = 6;
  localparam int H_ACT = 16;
  localparam int V_ST  = 3;
  localparam int V_ACT = 8;
  localparam int LINE  = 30;
  localparam int HSW   = 4;
  localparam int FRAME = 14;
  localparam int VSW   = 2;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b1;

  logic        pclk, rst, hs, vs;
  logic [11:0] rgb;
  logic [10:0] hcount_out, vcount_out, line_len, frame_lines;
  logic        de, locked, err, frame_done;
  logic [11:0] rgb_out;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sum;

  vga_sync_decoder #(
    .H_START (H_ST),
    .H_ACTIVE(H_ACT),
    .V_START (V_ST),
    .V_ACTIVE(V_ACT),
    .HS_POL  (HS_POL),
    .VS_POL  (VS_POL)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hs         (hs),
    .vs         (vs),
    .rgb        (rgb),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .de         (de),
    .rgb_out    (rgb_out),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .locked     (locked),
    .err        (err),
    .err_cnt    (err_cnt),
    .frame_sum  (frame_sum),
    .frame_done (frame_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, want, $time);
  endtask

  // Reference model: expected outputs per driven sample, consumed two samples later
  typedef struct {
    int hc, vc, de, rgb, ll, fl, lk, err, ec, fs, fd;
  } exp_t;
  exp_t exp_q[$];

  bit m_hprev, m_vprev, m_vpend, m_locked, m_have_ref;
  int m_h, m_v, m_ll, m_fl, m_ref_line, m_ref_lines, m_ec, m_acc, m_sum;

  task automatic model_reset();
    m_hprev = 0; m_vprev = 0; m_vpend = 0; m_locked = 0; m_have_ref = 0;
    m_h = 0; m_v = 0; m_ll = 0; m_fl = 0; m_ref_line = 0; m_ref_lines = 0;
    m_ec = 0; m_acc = 0; m_sum = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input bit h_act, input bit v_act, input logic [11:0] c);
    exp_t e;
    bit   h_edge, v_edge, fs, lost, in_win;
    int   meas, lmeas;
    h_edge  = h_act && !m_hprev;
    v_edge  = v_act && !m_vprev;
    m_hprev = h_act;
    m_vprev = v_act;
    fs      = h_edge && (m_vpend || v_edge);
    meas    = (m_h + 1) % 2048;
    lmeas   = (m_v + 1) % 2048;
    lost    = 0;
    if (h_edge) begin
      m_ll = meas;
      m_h  = 0;
      if (m_locked && meas != m_ref_line) lost = 1;
    end else if (m_h < 2047) m_h++;
    if (fs) begin
      m_fl    = lmeas;
      m_v     = 0;
      m_vpend = 0;
      if (m_locked) begin
        if (lmeas != m_ref_lines) lost = 1;
      end else if (m_have_ref && meas == m_ref_line && lmeas == m_ref_lines) begin
        m_locked = 1;
      end else begin
        m_have_ref  = 1;
        m_ref_line  = meas;
        m_ref_lines = lmeas;
      end
    end else begin
      if (h_edge && m_v < 2047) m_v++;
      if (v_edge) m_vpend = 1;
    end
    if (lost) begin
      m_locked   = 0;
      m_have_ref = 0;
      if (m_ec < 255) m_ec++;
    end
    in_win = (m_h >= H_ST) && (m_h < H_ST + H_ACT) && (m_v >= V_ST) && (m_v < V_ST + V_ACT);
    if (fs) begin
      m_sum = m_acc;
      m_acc = 0;
    end else if (in_win) begin
      m_acc = (((m_acc << 1) | (m_acc >> 15)) & 16'hffff) ^ int'(c);
    end
    e.hc = m_h; e.vc = m_v; e.de = int'(in_win); e.rgb = int'(c);
    e.ll = m_ll; e.fl = m_fl; e.lk = int'(m_locked); e.err = int'(lost);
    e.ec = m_ec; e.fd = int'(fs);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    e.fs = m_sum;
`else
    e.fs = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic compare_exp(input exp_t e);
    check_eq("hcount_out", int'(hcount_out), e.hc);
    check_eq("vcount_out", int'(vcount_out), e.vc);
    check_eq("de", int'(de), e.de);
    check_eq("rgb_out", int'(rgb_out), e.rgb);
    check_eq("line_len", int'(line_len), e.ll);
    check_eq("frame_lines", int'(frame_lines), e.fl);
    check_eq("locked", int'(locked), e.lk);
    check_eq("err", int'(err), e.err);
    check_eq("err_cnt", int'(err_cnt), e.ec);
    check_eq("frame_sum", int'(frame_sum), e.fs);
    check_eq("frame_done", int'(frame_done), e.fd);
  endtask

  // Drive one sample; compare the DUT against the sample driven two cycles ago
  task automatic step(input bit h_act, input bit v_act, input logic [11:0] c);
    exp_t e;
    @(posedge pclk);
    #1;
    hs  = h_act ? HS_POL : !HS_POL;
    vs  = v_act ? VS_POL : !VS_POL;
    rgb = c;
    model_push(h_act, v_act, c);
    @(negedge pclk);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      compare_exp(e);
    end
  endtask

  // Lines y0..y1-1 of a frame; one line may take a different length
  task automatic frame(input int y0, input int y1, input int short_idx, input int short_len,
                       input bit single);
    int          len;
    logic [11:0] c;
    for (int y = y0; y < y1; y++) begin
      len = (y == short_idx) ? short_len : LINE;
      for (int x = 0; x < len; x++) begin
        if (single) c = (x == H_ST && y == V_ST) ? 12'hfff : 12'h000;
        else c = 12'($urandom);
        step(x < HSW, y < VSW, c);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #1;
    rst = 1'b1;
    hs  = !HS_POL;
    vs  = !VS_POL;
    rgb = 12'h000;
    #1;
    check_eq("rst_hcount", int'(hcount_out), 0);
    check_eq("rst_vcount", int'(vcount_out), 0);
    check_eq("rst_de", int'(de), 0);
    check_eq("rst_rgb_out", int'(rgb_out), 0);
    check_eq("rst_line_len", int'(line_len), 0);
    check_eq("rst_frame_lines", int'(frame_lines), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_err_cnt", int'(err_cnt), 0);
    check_eq("rst_frame_sum", int'(frame_sum), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    model_reset();
    // The first two post-release edges process the reset-cleared input stage
    // and the idle pins held during reset
    model_push(1'b0, 1'b0, 12'h000);
    model_push(1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    rst = 1'b1;
    hs  = !HS_POL;
    vs  = !VS_POL;
    rgb = 12'h000;
    model_reset();
    do_reset();

    // Nominal timing: lock at the third frame start
    frame(0, FRAME, -1, 0, 1'b0);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("pre_lock_locked", int'(locked), 0);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("nom_locked", int'(locked), 1);
    check_eq("nom_line_len", int'(line_len), LINE);
    check_eq("nom_frame_lines", int'(frame_lines), FRAME);
    check_eq("nom_err_cnt", int'(err_cnt), 0);

    // Single bright pixel at the active origin
    frame(0, FRAME, -1, 0, 1'b1);
    frame(0, FRAME, -1, 0, 1'b0);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    check_eq("single_px_sum", int'(frame_sum), 'h87ff);
`else
    check_eq("single_px_sum", int'(frame_sum), 0);
`endif

    // Short line while locked, then relock two frame starts later
    frame(0, FRAME, 5, LINE - 1, 1'b0);
    check_eq("short_line_locked", int'(locked), 0);
    check_eq("short_line_err_cnt", int'(err_cnt), 1);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("relock_pending", int'(locked), 0);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("relock_locked", int'(locked), 1);

    // Short frame
    frame(0, FRAME - 1, -1, 0, 1'b0);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("short_frame_lines", int'(frame_lines), FRAME - 1);
    check_eq("short_frame_err_cnt", int'(err_cnt), 2);
    check_eq("short_frame_locked", int'(locked), 0);

    // Randomly jittered line lengths
    for (int i = 0; i < 4; i++) begin
      frame(0, FRAME, int'($urandom_range(0, FRAME - 1)), int'($urandom_range(26, 33)), 1'b0);
    end

    // Reset mid-frame, finish the partial frame, relock after two full frames
    frame(0, FRAME, -1, 0, 1'b0);
    frame(0, 6, -1, 0, 1'b0);
    do_reset();
    frame(6, FRAME, -1, 0, 1'b0);
    frame(0, FRAME, -1, 0, 1'b0);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("post_rst_not_locked", int'(locked), 0);
    frame(0, FRAME, -1, 0, 1'b0);
    check_eq("post_rst_locked", int'(locked), 1);

    // Stuck hs: hcount saturates and de stays low
    for (int i = 0; i < 2100; i++) step(1'b0, 1'b0, 12'($urandom));
    check_eq("stuck_hcount", int'(hcount_out), 2047);
    check_eq("stuck_de", int'(de), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
